// File: rtl/cnn_pkg.sv
// cnn_pkg: shared types and constants for the CNN host-side feeder
package cnn_pkg;
    localparam int PIX_W = 16;
    localparam int CAT_W = 4;
    typedef logic signed [PIX_W-1:0] pixel_t;
    typedef logic signed [CAT_W-1:0] cat_t;
    typedef enum logic [2:0] {IDLE, LOAD, WAIT_STORE, START, RUN, REPORT} feeder_state_t;
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hff) ? v : v + 8'd1;
    endfunction
endpackage

// File: rtl/feeder_timeout_ctr.sv
// feeder_timeout_ctr: counts enabled cycles since the last clear and flags when LIMIT is reached
module feeder_timeout_ctr #(
    parameter int LIMIT = 65535
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int W = $clog2(LIMIT + 1);
    logic [W-1:0] count;
    assign expired = count == W'(LIMIT);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) count <= '0;
        else if (clear) count <= '0;
        else if (enable && !expired) count <= count + W'(1);
    end
endmodule

// File: rtl/image_feeder.sv
// image_feeder: streams images from pixel memory into the CNN core and reports one result per image
module image_feeder
    import cnn_pkg::*;
#(
    parameter int NUM_PIXELS = 784,
    parameter int NUM_IMAGES = 10,
    parameter int TIMEOUT    = 65535
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    run,
    output logic [19:0]             mem_addr,
    output logic                    mem_rd,
    input  logic signed [PIX_W-1:0] mem_data,
    input  logic signed [CAT_W-1:0] label,
    output logic signed [PIX_W-1:0] image_pixel,
    output logic                    store,
    input  logic                    store_finish,
    output logic                    net_start,
    input  logic signed [CAT_W-1:0] categories,
    input  logic                    one_end,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic signed [CAT_W-1:0] res_category,
    output logic [7:0]              res_index,
    output logic                    res_timeout,
    output logic [7:0]              correct_cnt,
    output logic                    busy,
    output logic                    done
);
    localparam int PW = $clog2(NUM_PIXELS + 1);
    feeder_state_t state;
    logic [PW-1:0] pix_cnt;
    logic [7:0]    img_idx;
    logic          expired;
    logic          timing;

    // one counter serves both waits; START between them clears it
    assign timing = (state == WAIT_STORE) || (state == RUN);

    feeder_timeout_ctr #(.LIMIT(TIMEOUT)) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clear  (!timing),
        .enable (1'b1),
        .expired(expired)
    );

    assign busy        = state != IDLE;
    assign image_pixel = store ? mem_data : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            pix_cnt      <= '0;
            img_idx      <= '0;
            mem_addr     <= '0;
            mem_rd       <= 1'b0;
            store        <= 1'b0;
            net_start    <= 1'b0;
            res_valid    <= 1'b0;
            res_category <= '0;
            res_index    <= '0;
            res_timeout  <= 1'b0;
            correct_cnt  <= '0;
            done         <= 1'b0;
        end else begin
            store <= mem_rd;
            done  <= 1'b0;
            case (state)
                IDLE: if (run) begin
                    state       <= LOAD;
                    img_idx     <= '0;
                    correct_cnt <= '0;
                    mem_rd      <= 1'b1;
                    mem_addr    <= '0;
                    pix_cnt     <= PW'(1);
                end
                LOAD: begin
                    if (pix_cnt != PW'(NUM_PIXELS)) begin
                        mem_rd   <= 1'b1;
                        mem_addr <= mem_addr + 20'd1;
                        pix_cnt  <= pix_cnt + PW'(1);
                    end else mem_rd <= 1'b0;
                    if (store && !mem_rd) state <= WAIT_STORE;
                end
                WAIT_STORE: if (store_finish) begin
                    state     <= START;
                    net_start <= 1'b1;
                end else if (expired) begin
                    state        <= REPORT;
                    res_valid    <= 1'b1;
                    res_timeout  <= 1'b1;
                    res_category <= '0;
                    res_index    <= img_idx;
                end
                START: begin
                    net_start <= 1'b0;
                    state     <= RUN;
                end
                RUN: if (one_end || expired) begin
                    state        <= REPORT;
                    res_valid    <= 1'b1;
                    res_index    <= img_idx;
                    res_timeout  <= !one_end;
                    res_category <= one_end ? categories : '0;
                    if (one_end && categories == label) correct_cnt <= sat_inc(correct_cnt);
                end
                REPORT: if (res_ready) begin
                    res_valid <= 1'b0;
                    if (img_idx == 8'(NUM_IMAGES - 1)) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end else begin
                        // images are contiguous, so the next base follows the last address read
                        state    <= LOAD;
                        img_idx  <= img_idx + 8'd1;
                        mem_rd   <= 1'b1;
                        mem_addr <= mem_addr + 20'd1;
                        pix_cnt  <= PW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_image_feeder.sv
// tb_image_feeder: directed batches checked against a model of the pixel stream and result queue
module tb_image_feeder;
    localparam int N = 4;
    localparam int IMGS = 2;
    localparam int TO = 20;

    logic clk = 0, reset = 1, run = 0, store_finish = 0, one_end = 0, res_ready = 0;
    logic [19:0] mem_addr;
    logic mem_rd, store, net_start, res_valid, res_timeout, busy, done;
    logic signed [15:0] mem_data = 0, image_pixel;
    logic signed [3:0] label = 0, categories = 0, res_category;
    logic [7:0] res_index, correct_cnt;
    int tests = 0, fails = 0;

    logic signed [15:0] mem [0:N*IMGS-1] = '{16'sd5, -16'sd3, 16'sd7, 16'sd0, 16'sd1, 16'sd2, -16'sd8, 16'sd100};
    int exp_px [4] = '{5, -3, 7, 0};

    typedef struct { int cat; int idx; int to; int cnt; } res_t;
    res_t exp_q[$];
    int m_correct = 0;
    int m_img = 0, m_pix = 0, prev_addr = 0;
    bit prev_rd = 0;
    int addrs[$];
    int pix[$];

    image_feeder #(.NUM_PIXELS(N), .NUM_IMAGES(IMGS), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .run(run), .mem_addr(mem_addr), .mem_rd(mem_rd),
        .mem_data(mem_data), .label(label), .image_pixel(image_pixel), .store(store),
        .store_finish(store_finish), .net_start(net_start), .categories(categories),
        .one_end(one_end), .res_valid(res_valid), .res_ready(res_ready),
        .res_category(res_category), .res_index(res_index), .res_timeout(res_timeout),
        .correct_cnt(correct_cnt), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_rd) mem_data <= mem[mem_addr[2:0]];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit cond(input int w);
        return w == 0 ? store : w == 1 ? !store : w == 2 ? net_start : res_valid;
    endfunction

    task automatic wait_for(input int w, input string name);
        int n = 0;
        while (!cond(w) && n < 200) begin
            tick();
            n++;
        end
        chk(name, int'(cond(w)), 1);
    endtask

    task automatic expect_result(input int cat, input int idx, input int to);
        res_t r;
        if (to == 0 && cat == int'(label)) m_correct = (m_correct == 255) ? 255 : m_correct + 1;
        r.cat = cat;
        r.idx = idx;
        r.to = to;
        r.cnt = m_correct;
        exp_q.push_back(r);
    endtask

    task automatic start_batch();
        m_correct = 0;
        run = 1;
        tick();
        run = 0;
    endtask

    task automatic accept();
        res_ready = 1;
        tick();
        res_ready = 0;
    endtask

    // reference: image k reads addresses k*N.. in order, each read stored one cycle later
    always @(negedge clk) begin
        if (reset) begin
            m_img = 0;
            m_pix = 0;
            prev_rd = 0;
        end else begin
            chk("store_pipe", int'(store), int'(prev_rd));
            if (prev_rd) chk("pixel", int'(image_pixel), int'(mem[prev_addr]));
            if (mem_rd) begin
                chk("rd_addr", int'(mem_addr), m_img * N + m_pix);
                chk("rd_while_valid", int'(res_valid), 0);
                prev_addr = int'(mem_addr[2:0]);
                m_pix++;
                if (m_pix == N) begin
                    m_pix = 0;
                    m_img = (m_img + 1) % IMGS;
                end
            end
            prev_rd = mem_rd;
            if (res_valid) begin
                if (exp_q.size() == 0) chk("res_unexpected", int'(res_valid), 0);
                else begin
                    chk("res_category", int'(res_category), exp_q[0].cat);
                    chk("res_index", int'(res_index), exp_q[0].idx);
                    chk("res_timeout", int'(res_timeout), exp_q[0].to);
                    chk("correct_cnt", int'(correct_cnt), exp_q[0].cnt);
                    if (res_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) tick();
        chk("rst_busy", int'(busy), 0);
        chk("rst_store", int'(store), 0);
        chk("rst_mem_rd", int'(mem_rd), 0);
        chk("rst_valid", int'(res_valid), 0);
        chk("rst_cnt", int'(correct_cnt), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_net_start", int'(net_start), 0);
        chk("rst_addr", int'(mem_addr), 0);
        reset = 0;
        tick();

        // abort mid-load
        start_batch();
        wait_for(0, "load_store_hi");
        tick();
        tick();
        chk("midload_store_before", int'(store), 1);
        reset = 1;
        #1;
        chk("midload_store", int'(store), 0);
        chk("midload_busy", int'(busy), 0);
        chk("midload_rd", int'(mem_rd), 0);
        tick();
        reset = 0;
        tick();

        // batch 1: pixel stream, start pulse, results, back-pressure
        label = 3;
        start_batch();
        chk("restart_addr", int'(mem_addr), 0);
        for (int i = 0; i < 6; i++) begin
            if (mem_rd) addrs.push_back(int'(mem_addr));
            if (store) pix.push_back(int'(image_pixel));
            tick();
        end
        chk("n_reads", addrs.size(), 4);
        chk("n_stores", pix.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk("lit_addr", i < addrs.size() ? addrs[i] : -1, i);
            chk("lit_pixel", i < pix.size() ? pix[i] : -999, exp_px[i]);
        end
        one_end = 1;
        categories = 1;
        tick();
        one_end = 0;
        chk("ws_ignores_one_end", int'(res_valid), 0);
        store_finish = 1;
        tick();
        store_finish = 0;
        n = 0;
        for (int i = 0; i < 5; i++) begin
            if (net_start) n++;
            tick();
        end
        chk("net_start_pulses", n, 1);
        categories = 3;
        one_end = 1;
        expect_result(3, 0, 0);
        tick();
        one_end = 0;
        wait_for(3, "res_valid0");
        chk("lit_cat0", int'(res_category), 3);
        chk("lit_cnt0", int'(correct_cnt), 1);
        for (int i = 0; i < 50; i++) begin
            chk("bp_valid", int'(res_valid), 1);
            chk("bp_rd", int'(mem_rd), 0);
            chk("bp_cat", int'(res_category), 3);
            chk("bp_idx", int'(res_index), 0);
            tick();
        end
        label = 7;
        accept();
        chk("next_rd", int'(mem_rd), 1);
        chk("next_addr", int'(mem_addr), N);
        wait_for(0, "img1_store_hi");
        wait_for(1, "img1_store_lo");
        store_finish = 1;
        tick();
        store_finish = 0;
        wait_for(2, "img1_net_start");
        tick();
        categories = 2;
        one_end = 1;
        expect_result(2, 1, 0);
        tick();
        one_end = 0;
        wait_for(3, "res_valid1");
        chk("lit_cat1", int'(res_category), 2);
        chk("lit_cnt1", int'(correct_cnt), 1);
        chk("lit_idx1", int'(res_index), 1);
        accept();
        chk("done_pulse", int'(done), 1);
        chk("done_busy", int'(busy), 0);
        chk("done_valid", int'(res_valid), 0);
        tick();
        chk("done_drop", int'(done), 0);
        label = 5;
        categories = 5;
        one_end = 1;
        tick();
        one_end = 0;
        tick();
        chk("idle_one_end_cnt", int'(correct_cnt), 1);
        chk("idle_one_end_valid", int'(res_valid), 0);
        chk("idle_one_end_busy", int'(busy), 0);

        // batch 2: store_finish timeout, then one_end on the RUN expiry cycle
        label = 0;
        start_batch();
        expect_result(0, 0, 1);
        wait_for(0, "b2_store_hi");
        wait_for(1, "b2_store_lo");
        n = 0;
        while (!res_valid && n < 100) begin
            n++;
            tick();
        end
        chk("ws_timeout_cycles", n, TO + 1);
        chk("ws_timeout_flag", int'(res_timeout), 1);
        chk("ws_timeout_cnt", int'(correct_cnt), 0);
        label = 6;
        accept();
        wait_for(0, "b2i1_store_hi");
        wait_for(1, "b2i1_store_lo");
        store_finish = 1;
        tick();
        store_finish = 0;
        wait_for(2, "b2i1_net_start");
        repeat (TO + 1) tick();
        categories = 6;
        one_end = 1;
        expect_result(6, 1, 0);
        tick();
        one_end = 0;
        wait_for(3, "b2i1_valid");
        chk("tie_timeout", int'(res_timeout), 0);
        chk("tie_cat", int'(res_category), 6);
        chk("tie_cnt", int'(correct_cnt), 1);
        accept();
        chk("b2_done", int'(done), 1);

        // batch 3: spurious store_finish in LOAD, RUN timeout
        label = 4;
        start_batch();
        expect_result(0, 0, 1);
        store_finish = 1;
        tick();
        store_finish = 0;
        wait_for(1, "b3_store_lo");
        repeat (3) tick();
        chk("b3_wait_valid", int'(res_valid), 0);
        store_finish = 1;
        tick();
        store_finish = 0;
        wait_for(2, "b3_net_start");
        wait_for(3, "b3_valid");
        chk("run_timeout_flag", int'(res_timeout), 1);
        chk("run_timeout_cat", int'(res_category), 0);
        chk("run_timeout_cnt", int'(correct_cnt), 0);
        accept();
        wait_for(0, "b3i1_store_hi");
        wait_for(1, "b3i1_store_lo");
        store_finish = 1;
        tick();
        store_finish = 0;
        wait_for(2, "b3i1_net_start");
        tick();
        categories = 4;
        one_end = 1;
        expect_result(4, 1, 0);
        tick();
        one_end = 0;
        wait_for(3, "b3i1_valid");
        chk("b3_cnt", int'(correct_cnt), 1);
        accept();
        chk("b3_done", int'(done), 1);
        chk("b3_busy", int'(busy), 0);
        chk("exp_q_empty", exp_q.size(), 0);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
